// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg
// Shared constants and types for the D-stage hazard controller.
//   - Default scoreboard depth, register-address width and Tuse/Tnew width.
//   - Tuse/Tnew encodings per instruction class, used by the decoder when it
//     builds the hints that hazard_ctrl consumes.
//   - Default HI/LO busy lengths for mult/multu and div/divu.
//   - Per-source classification produced by the forwarding priority encoder.
package hazard_ctrl_pkg;

  // Default geometry
  localparam int unsigned DEF_STAGES   = 3;
  localparam int unsigned DEF_AW       = 5;
  localparam int unsigned DEF_TW       = 2;

  // Default HI/LO busy lengths after a multiply/divide issues
  localparam int unsigned DEF_MULT_CYC = 5;
  localparam int unsigned DEF_DIV_CYC  = 10;

  // Tuse: cycles from D until the operand is actually consumed.
  // All-ones means the operand is not read at all.
  localparam logic [DEF_TW-1:0] TUSE_D    = 2'd0;  // branches, jr
  localparam logic [DEF_TW-1:0] TUSE_E    = 2'd1;  // ALU ops, address calc
  localparam logic [DEF_TW-1:0] TUSE_M    = 2'd2;  // store data
  localparam logic [DEF_TW-1:0] TUSE_NONE = 2'd3;

  // Tnew: cycles after entering E until the result exists.
  localparam logic [DEF_TW-1:0] TNEW_NOW  = 2'd0;  // lui, jal link value
  localparam logic [DEF_TW-1:0] TNEW_ALU  = 2'd1;  // ALU result at end of E
  localparam logic [DEF_TW-1:0] TNEW_LOAD = 2'd2;  // load data at end of M

  // How a single source operand resolves against the scoreboard.
  //   SRC_IGNORE : operand not read, register 0, or D holds a bubble
  //   SRC_RF     : no usable match, or the value will arrive in time via
  //                downstream forwarding; D reads the register file
  //   SRC_FWD    : youngest match already has its result; forward from it
  //   SRC_STALL  : youngest match produces too late; D must stall
  typedef enum logic [1:0] {
    SRC_IGNORE = 2'd0,
    SRC_RF     = 2'd1,
    SRC_FWD    = 2'd2,
    SRC_STALL  = 2'd3
  } src_class_e;

endpackage : hazard_ctrl_pkg

// File: rtl/hazard_slot.sv
// hazard_slot
// One scoreboard entry: the destination register and remaining Tnew of the
// instruction currently sitting in one downstream stage.
// Ports:
//   clk, reset_n         clock and asynchronous active-low reset
//   in_dst, in_tnew      entry arriving from the previous stage (or from D)
//   rs, rt               D-stage source addresses to compare against
//   dst, tnew            current contents of this entry
//   rs_match, rt_match   this entry writes the register D wants to read
// DECREMENT selects whether the incoming Tnew is aged by one cycle on the way
// in. The first slot takes D's Tnew untouched; every later slot ages it.
module hazard_slot
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned AW        = DEF_AW,
  parameter int unsigned TW        = DEF_TW,
  parameter bit          DECREMENT = 1'b1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] in_dst,
  input  logic [TW-1:0] in_tnew,
  input  logic [AW-1:0] rs,
  input  logic [AW-1:0] rt,
  output logic [AW-1:0] dst,
  output logic [TW-1:0] tnew,
  output logic          rs_match,
  output logic          rt_match
);

  logic [TW-1:0] next_tnew;

  // Saturating age: a result that already exists stays at zero rather than
  // wrapping to all-ones and looking like a brand-new long-latency producer.
  always_comb begin
    next_tnew = in_tnew;
    if (DECREMENT && (in_tnew != '0)) begin
      next_tnew = in_tnew - TW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dst  <= '0;
      tnew <= '0;
    end else begin
      dst  <= in_dst;
      tnew <= next_tnew;
    end
  end

  // $0 is hard-wired, so an entry writing it never produces a hazard.
  assign rs_match = (dst != '0) && (dst == rs);
  assign rt_match = (dst != '0) && (dst == rt);

endmodule : hazard_slot

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Stall / forward controller beside the D-stage decoder. Tracks in-flight
// destinations in a scoreboard (slot 1 = E, 2 = M, 3 = W), resolves each
// source against the youngest matching slot, and owns the HI/LO busy counter
// for multi-cycle mult/div.
// Ports:
//   clk, reset_n              clock and asynchronous active-low reset
//   d_valid                   D holds a real instruction (0 = bubble)
//   d_rs, d_rt                source register addresses
//   d_rs_tuse, d_rt_tuse      cycles until each operand is consumed
//                             (all-ones = operand not read)
//   d_dst, d_tnew             destination register (0 = none) and latency
//   d_md_start, d_md_is_div   instruction starts a multiply / a divide
//   d_hilo_use                instruction touches HI/LO
//   stall                     freeze PC and F/D, bubble into E
//   fwd_rs_sel, fwd_rt_sel    0 = register file, k = forward from slot k
//   md_busy                   HI/LO counter non-zero
// All outputs are combinational from inputs and current state.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned STAGES   = DEF_STAGES,
  parameter int unsigned AW       = DEF_AW,
  parameter int unsigned TW       = DEF_TW,
  parameter int unsigned MULT_CYC = DEF_MULT_CYC,
  parameter int unsigned DIV_CYC  = DEF_DIV_CYC,
  localparam int unsigned SW      = $clog2(STAGES + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          d_valid,
  input  logic [AW-1:0] d_rs,
  input  logic [AW-1:0] d_rt,
  input  logic [TW-1:0] d_rs_tuse,
  input  logic [TW-1:0] d_rt_tuse,
  input  logic [AW-1:0] d_dst,
  input  logic [TW-1:0] d_tnew,
  input  logic          d_md_start,
  input  logic          d_md_is_div,
  input  logic          d_hilo_use,
  output logic          stall,
  output logic [SW-1:0] fwd_rs_sel,
  output logic [SW-1:0] fwd_rt_sel,
  output logic          md_busy
);

  localparam int unsigned   MD_MAX  = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int unsigned   CW      = $clog2(MD_MAX + 1);
  localparam logic [TW-1:0] NO_TUSE = {TW{1'b1}};

  // Scoreboard contents and per-slot match flags
  logic [AW-1:0] slot_dst  [1:STAGES];
  logic [TW-1:0] slot_tnew [1:STAGES];
  logic          rs_match  [1:STAGES];
  logic          rt_match  [1:STAGES];

  // What D pushes into slot 1 this cycle
  logic          issue;
  logic [AW-1:0] ins_dst;
  logic [TW-1:0] ins_tnew;

  // Source resolution
  logic          rs_active;
  logic          rt_active;
  logic [SW-1:0] rs_slot;
  logic [SW-1:0] rt_slot;
  logic [TW-1:0] rs_tnew;
  logic [TW-1:0] rt_tnew;
  src_class_e    rs_class;
  src_class_e    rt_class;
  logic          hilo_hazard;

  // HI/LO busy counter
  logic [CW-1:0] md_cnt;

  // A stalled D instruction must not enter E; it leaves a bubble behind it,
  // which also stops a stalled mult/div from loading the counter early.
  assign issue    = d_valid && !stall;
  assign ins_dst  = issue ? d_dst  : '0;
  assign ins_tnew = issue ? d_tnew : '0;

  // Slot 1 is fed from D; every later slot is fed from its predecessor and
  // ages Tnew by one. The last slot's contents simply fall off.
  for (genvar k = 1; k <= STAGES; k++) begin : g_slot
    if (k == 1) begin : g_head
      hazard_slot #(
        .AW        (AW),
        .TW        (TW),
        .DECREMENT (1'b0)
      ) u_slot (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_dst   (ins_dst),
        .in_tnew  (ins_tnew),
        .rs       (d_rs),
        .rt       (d_rt),
        .dst      (slot_dst[k]),
        .tnew     (slot_tnew[k]),
        .rs_match (rs_match[k]),
        .rt_match (rt_match[k])
      );
    end else begin : g_tail
      hazard_slot #(
        .AW        (AW),
        .TW        (TW),
        .DECREMENT (1'b1)
      ) u_slot (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_dst   (slot_dst[k-1]),
        .in_tnew  (slot_tnew[k-1]),
        .rs       (d_rs),
        .rt       (d_rt),
        .dst      (slot_dst[k]),
        .tnew     (slot_tnew[k]),
        .rs_match (rs_match[k]),
        .rt_match (rt_match[k])
      );
    end
  end

  // Decide what to do with a source once its youngest matching slot is known.
  // A producer whose result lands no later than the operand is consumed needs
  // neither a stall nor a D-stage forward: later-stage muxes pick it up.
  function automatic src_class_e classify(input logic          hit,
                                          input logic [TW-1:0] tnew,
                                          input logic [TW-1:0] tuse);
    if (!hit) begin
      return SRC_RF;
    end
    if (tnew > tuse) begin
      return SRC_STALL;
    end
    if (tnew == '0) begin
      return SRC_FWD;
    end
    return SRC_RF;
  endfunction

  assign rs_active = d_valid && (d_rs != '0) && (d_rs_tuse != NO_TUSE);
  assign rt_active = d_valid && (d_rt != '0) && (d_rt_tuse != NO_TUSE);

  // Priority encoders: scanning from the oldest slot to the youngest means
  // the last hit written is the smallest k, i.e. the most recent producer.
  always_comb begin
    rs_slot = '0;
    rs_tnew = '0;
    rt_slot = '0;
    rt_tnew = '0;
    for (int k = STAGES; k >= 1; k--) begin
      if (rs_match[k]) begin
        rs_slot = SW'(k);
        rs_tnew = slot_tnew[k];
      end
      if (rt_match[k]) begin
        rt_slot = SW'(k);
        rt_tnew = slot_tnew[k];
      end
    end
  end

  assign rs_class = rs_active ? classify(rs_slot != '0, rs_tnew, d_rs_tuse) : SRC_IGNORE;
  assign rt_class = rt_active ? classify(rt_slot != '0, rt_tnew, d_rt_tuse) : SRC_IGNORE;

  assign fwd_rs_sel = (rs_class == SRC_FWD) ? rs_slot : '0;
  assign fwd_rt_sel = (rt_class == SRC_FWD) ? rt_slot : '0;

  assign hilo_hazard = d_valid && d_hilo_use && md_busy;

  assign stall = (rs_class == SRC_STALL) || (rt_class == SRC_STALL) || hilo_hazard;

  // HI/LO busy counter. A new mult/div can only load while idle, because any
  // HI/LO access with the counter running is itself stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      md_cnt <= '0;
    end else if (issue && d_md_start) begin
      md_cnt <= d_md_is_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - CW'(1);
    end
  end

  assign md_busy = (md_cnt != '0);

endmodule : hazard_ctrl

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised stall/forward controller for the pipelined MIPS core. It sits beside the D-stage decoder. Each cycle it takes per-instruction register-use and result-latency hints (Tuse/Tnew), tracks in-flight destinations in an internal scoreboard one slot per downstream stage, and produces the D-stage stall and the D-stage forwarding selects. It also owns the HI/LO busy counter for multi-cycle mult/div and stalls any HI/LO access while that counter is non-zero.

## Interface
- STAGES, 3: scoreboard depth, i.e. downstream stages tracked (slot 1 = E, 2 = M, 3 = W).
- AW, 5: register-address width.
- TW, 2: Tuse/Tnew width; all-ones (TUSE_NONE) means "operand not read".
- MULT_CYC, 5: HI/LO busy cycles after mult/multu issue.
- DIV_CYC, 10: HI/LO busy cycles after div/divu issue.
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- d_valid  in  1  D-stage holds a real instruction; 0 = bubble.
- d_rs, d_rt  in  AW  source register addresses.
- d_rs_tuse, d_rt_tuse  in  TW  cycles until each operand is consumed (0 = consumed in D).
- d_dst  in  AW  destination register; 0 = no write.
- d_tnew  in  TW  cycles after entering E until the result exists.
- d_md_start  in  1  instruction is mult/multu/div/divu.
- d_md_is_div  in  1  selects DIV_CYC over MULT_CYC.
- d_hilo_use  in  1  instruction touches HI/LO (md, mf, mt).
- stall  out  1  freeze PC and F/D, inject bubble into E.
- fwd_rs_sel, fwd_rt_sel  out  clog2(STAGES+1)  0 = register file, k = forward from slot k.
- md_busy  out  1  HI/LO counter non-zero.

## Operation
- Each scoreboard slot holds {dst[AW], tnew[TW]}.
- Per source s (rs, rt), the source is ignored when s == 0, tuse == TUSE_NONE, or d_valid == 0.
- Otherwise find the smallest k with slot[k].dst == s.
  - No match: sel = 0, no stall.
  - tnew_k > tuse: data hazard stall.
  - tnew_k == 0: sel = k.
  - 0 < tnew_k <= tuse: sel = 0, no stall. The value is picked up by downstream forwarding, which is outside this block.
- HI/LO hazard: stall when d_valid && d_hilo_use && md_busy.
- stall is the OR of rs hazard, rt hazard and HI/LO hazard.
- Scoreboard update at each posedge:
  - Slot 1 takes {d_dst, d_tnew} when d_valid && !stall; otherwise it takes {0, 0}.
  - slot[k+1] takes {slot[k].dst, sat0(slot[k].tnew − 1)}.
  - Slot STAGES contents fall off the end.
- MD counter (width to hold max(MULT_CYC, DIV_CYC)):
  - Loads DIV_CYC or MULT_CYC when d_valid && d_md_start && !stall.
  - Otherwise it decrements when non-zero.
  - Load has priority; load while busy cannot occur because it would stall.
- md_busy = (counter != 0).

## Timing
- stall, fwd_*_sel and md_busy are combinational from inputs and current state. There are no registered outputs.
- Scoreboard and counter update on the rising clk edge.
- Reset (asynchronous assert, synchronous-safe release):
  - All slots become {0, 0} and the counter becomes 0.
  - Therefore md_busy = 0, and stall = 0 and sel = 0 for any inputs.
- Reset mid-stall: stall drops immediately on assertion; no pending hazard survives.
- Simultaneous matches in several slots: the youngest slot (smallest k) always wins.
- Writes to $0 never match and never stall.
- Tnew saturates at 0 and never wraps.
- A stalled instruction re-evaluates every cycle against the shifted scoreboard. Stall duration is therefore tnew − tuse cycles, bounded by 2^TW − 1.

## Structure
- const.v gains:
  - TUSE_NONE.
  - Tuse/Tnew encodings per instruction class.
  - Default MULT_CYC / DIV_CYC.
- The decoder emits Tuse/Tnew from those constants.
- One sub-module, hazard_slot: a single scoreboard register with dst match and decrement logic. It is instantiated STAGES times via generate.
- A priority encoder and the MD counter sit in the top level.

## Test plan
- After reset with any inputs: stall = 0, sels = 0, md_busy = 0.
- lw $1 (tnew 2) issued, then addu $2,$1,$3 (rs_tuse 1):
  - Exactly 1 stall cycle.
  - Next cycle no stall, fwd_rs_sel = 0.
- lw $1 then beq $1,$0 (tuse 0):
  - 2 stall cycles.
  - Then fwd_rs_sel = 3 with stall = 0.
- addu $1 (tnew 0 at M) in slot 2 and addu $1 (tnew 1) in slot 1, then a reader with tuse 0:
  - Stall driven by slot 1, not slot 2.
  - Next cycle fwd_rs_sel = 2.
- mult issued, then mfhi immediately:
  - md_busy high 5 cycles (counter 5..1) with stall.
  - mfhi issues on cycle 6.
  - Repeat with div: 10 cycles.
- Reset asserted during a div stall:
  - stall and md_busy go 0 asynchronously.
  - Slots stay empty after release.
- Sources with addr 0, TUSE_NONE, or d_valid = 0 against a matching slot: never stall, sel = 0.
